// File: rtl/fb_scanout.sv
// fb_scanout: reads a 1bpp framebuffer line-by-line (128-byte lines) from memory and streams it as pixels.
// Latency: first pixel is valid the cycle after the first line response is captured; one pixel per handshake.
// Backpressure: pix_ready low freezes the pixel counter and all pixel outputs; mem_req_ready low holds valid/addr.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start                           one-cycle pulse, accepted only in IDLE
//   busy, done                      busy REQ..STREAM; done is a one-cycle pulse in FIN
//   mem_req_valid/ready/addr        line read request (128-byte aligned byte address)
//   mem_rsp_valid/data              1024-bit line response, byte b in bits [8b+7:8b]
//   pix_valid/ready/data            pixel stream
//   pix_sof/eol/eof                 first pixel of frame / last of row / last of frame
//
// Build option: define FB_SCANOUT_PREFETCH_EN to add a spare line buffer that is filled while the
// current line streams, so consecutive lines can be emitted without a gap. The pixel stream is the
// same in both builds; only the timing between lines differs.
module fb_scanout #(
  parameter int unsigned FB_WIDTH  = 64,
  parameter int unsigned FB_HEIGHT = 64,
  parameter logic [31:0] FB_BASE   = 32'h2000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [31:0]   mem_req_addr,
  input  logic          mem_rsp_valid,
  input  logic [1023:0] mem_rsp_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          pix_data,
  output logic          pix_sof,
  output logic          pix_eol,
  output logic          pix_eof
);

  localparam int unsigned NPIX   = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned NLINES = ((NPIX / 1024) < 1) ? 1 : (NPIX / 1024);
  // One spare bit so the counter can never wrap inside a frame.
  localparam int unsigned PW     = $clog2(NPIX) + 1;
  localparam int unsigned XW     = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
  localparam int unsigned LW     = (NLINES > 1) ? $clog2(NLINES) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    STREAM = 3'd3,
    FIN    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [XW-1:0] x_q, x_d;
  logic [LW-1:0] line_q, line_d;
  logic [1023:0] lbuf0_q;

  logic [9:0]    bit_idx;
  logic          cur_bit;
  logic          pix_hs;
  logic          frame_last;
  logic          line_last;
  logic          cap_cur;
  logic [LW-1:0] req_line;

`ifdef FB_SCANOUT_PREFETCH_EN
  logic [1023:0] lbuf1_q;
  logic          rd_sel_q, rd_sel_d;
  logic          pf_issued_q, pf_issued_d;
  logic          pf_wait_q, pf_wait_d;
  logic          pf_have_q, pf_have_d;
  logic          pf_req;
  logic          pf_acc_now;
  logic          pf_cap;
  logic          pf_swap;
`endif

  // Lines are 1024 pixels, so the bit within the current line is the low 10 bits of the pixel index.
  assign bit_idx    = 10'(pix_cnt_q);
  assign frame_last = (pix_cnt_q == PW'(NPIX - 1));
  assign line_last  = (bit_idx == 10'd1023) || frame_last;

  assign pix_valid  = (state_q == STREAM);
  assign pix_hs     = pix_valid && pix_ready;

`ifdef FB_SCANOUT_PREFETCH_EN
  assign cur_bit    = rd_sel_q ? lbuf1_q[bit_idx] : lbuf0_q[bit_idx];

  // The prefetch request for the next line is raised as soon as a non-final line starts streaming
  // and stays up until accepted (or until the line ends, when REQ takes over with the same address).
  assign pf_req     = (state_q == STREAM) && (line_q != LW'(NLINES - 1)) && !pf_issued_q;
  assign pf_acc_now = pf_req && mem_req_ready;
  // Only the response to our own outstanding prefetch is taken during STREAM.
  assign pf_cap     = (state_q == STREAM) && pf_wait_q && mem_rsp_valid;

  assign req_line      = (state_q == STREAM) ? (line_q + LW'(1)) : line_q;
  assign mem_req_valid = (state_q == REQ) || pf_req;
`else
  assign cur_bit       = lbuf0_q[bit_idx];
  assign req_line      = line_q;
  assign mem_req_valid = (state_q == REQ);
`endif

  assign mem_req_addr = mem_req_valid ? (FB_BASE + 32'({req_line, 7'd0})) : 32'd0;

  assign pix_data = pix_valid && cur_bit;
  assign pix_sof  = pix_valid && (pix_cnt_q == '0);
  assign pix_eol  = pix_valid && (x_q == XW'(FB_WIDTH - 1));
  assign pix_eof  = pix_valid && frame_last;

  assign busy = (state_q == REQ) || (state_q == WAIT) || (state_q == STREAM);
  assign done = (state_q == FIN);

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    x_d       = x_q;
    line_d    = line_q;
    cap_cur   = 1'b0;
`ifdef FB_SCANOUT_PREFETCH_EN
    pf_swap   = 1'b0;
    rd_sel_d  = rd_sel_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = REQ;
          pix_cnt_d = '0;
          x_d       = '0;
          line_d    = '0;
`ifdef FB_SCANOUT_PREFETCH_EN
          rd_sel_d  = 1'b0;
`endif
        end
      end

      REQ: begin
        if (mem_req_ready) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        // Captured into the buffer currently selected for reading.
        if (mem_rsp_valid) begin
          cap_cur = 1'b1;
          state_d = STREAM;
        end
      end

      STREAM: begin
        if (pix_hs) begin
          pix_cnt_d = pix_cnt_q + PW'(1);
          x_d       = (x_q == XW'(FB_WIDTH - 1)) ? '0 : (x_q + XW'(1));
          if (line_last) begin
            if (frame_last) begin
              state_d = FIN;
            end else begin
              line_d = line_q + LW'(1);
`ifdef FB_SCANOUT_PREFETCH_EN
              // Spare buffer becomes the read buffer. If its data is already there (or lands
              // this very cycle) keep streaming; otherwise the late response fills it in WAIT.
              pf_swap = 1'b1;
              if (pf_have_q || pf_cap) begin
                state_d = STREAM;
              end else if (pf_wait_q || pf_acc_now) begin
                state_d = WAIT;
              end else begin
                state_d = REQ;
              end
`else
              state_d = REQ;
`endif
            end
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef FB_SCANOUT_PREFETCH_EN
    if (pf_swap) begin
      rd_sel_d = ~rd_sel_q;
    end
`endif
  end

`ifdef FB_SCANOUT_PREFETCH_EN
  // Prefetch bookkeeping: issued -> waiting for data -> data held in spare buffer.
  always_comb begin
    pf_issued_d = pf_issued_q;
    pf_wait_d   = pf_wait_q;
    pf_have_d   = pf_have_q;
    if ((state_q != STREAM) || pf_swap) begin
      pf_issued_d = 1'b0;
      pf_wait_d   = 1'b0;
      pf_have_d   = 1'b0;
    end else begin
      if (pf_acc_now) begin
        pf_issued_d = 1'b1;
        pf_wait_d   = 1'b1;
      end
      if (pf_cap) begin
        pf_wait_d = 1'b0;
        pf_have_d = 1'b1;
      end
    end
  end
`endif

  // State and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pix_cnt_q   <= '0;
      x_q         <= '0;
      line_q      <= '0;
`ifdef FB_SCANOUT_PREFETCH_EN
      rd_sel_q    <= 1'b0;
      pf_issued_q <= 1'b0;
      pf_wait_q   <= 1'b0;
      pf_have_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      x_q         <= x_d;
      line_q      <= line_d;
`ifdef FB_SCANOUT_PREFETCH_EN
      rd_sel_q    <= rd_sel_d;
      pf_issued_q <= pf_issued_d;
      pf_wait_q   <= pf_wait_d;
      pf_have_q   <= pf_have_d;
`endif
    end
  end

  // Line buffers hold data only; their content is never observed outside STREAM, so no reset.
  always_ff @(posedge clk) begin
`ifdef FB_SCANOUT_PREFETCH_EN
    if ((cap_cur && !rd_sel_q) || (pf_cap && rd_sel_q)) begin
      lbuf0_q <= mem_rsp_data;
    end
    if ((cap_cur && rd_sel_q) || (pf_cap && !rd_sel_q)) begin
      lbuf1_q <= mem_rsp_data;
    end
`else
    if (cap_cur) begin
      lbuf0_q <= mem_rsp_data;
    end
`endif
  end

endmodule

// File: tb/tb_fb_scanout.sv
`timescale 1ns/1ps
module tb_fb_scanout;

  localparam int W       = 64;
  localparam int H       = 64;
  localparam int NPIX    = W * H;
  localparam int FBBYTES = NPIX / 8;
  localparam int NLINES  = NPIX / 1024;
  localparam logic [31:0] BASE = 32'h2000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [31:0]   mem_req_addr;
  logic          mem_rsp_valid;
  logic [1023:0] mem_rsp_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_data;
  logic          pix_sof;
  logic          pix_eol;
  logic          pix_eof;

  always #5 clk = ~clk;

  fb_scanout #(.FB_WIDTH(W), .FB_HEIGHT(H), .FB_BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input longint act, input longint min);
    n_cmp++;
    if (act < min) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected at least %0d", name, act, min);
    end
  endtask

  // ---------------- memory + monitor ----------------
  logic [7:0]   fbmem [0:FBBYTES-1];
  int           lat        = 3;
  int           stall_left = 0;
  int           ready_mode = 0;   // 0: always ready, 1: alternate, 2: random (3/4 ready)
  int unsigned  cyc        = 0;
  logic [31:0]  pend_addr [$];
  int unsigned  pend_due  [$];
  logic [31:0]  req_log   [$];
  logic         mon_data  [$];
  logic [2:0]   mon_flags [$];
  int unsigned  mon_cyc   [$];
  int           done_cnt = 0;
  int           stab_err = 0;
  logic         req_stalled = 1'b0;
  logic [31:0]  req_addr_hold;
  logic         pix_stalled = 1'b0;
  logic [3:0]   pix_hold;
  logic [31:0]  rsp_a;
  int           rsp_off;

  initial begin
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    pix_ready     = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (req_stalled && !(mem_req_valid && mem_req_addr == req_addr_hold)) stab_err++;
        if (pix_stalled && !(pix_valid && {pix_data, pix_sof, pix_eol, pix_eof} == pix_hold)) stab_err++;
        req_stalled   = mem_req_valid && !mem_req_ready;
        req_addr_hold = mem_req_addr;
        pix_stalled   = pix_valid && !pix_ready;
        pix_hold      = {pix_data, pix_sof, pix_eol, pix_eof};
        if (mem_req_valid && mem_req_ready) begin
          pend_addr.push_back(mem_req_addr);
          pend_due.push_back(cyc + 1 + lat);
          req_log.push_back(mem_req_addr);
        end
        if (pix_valid && pix_ready) begin
          mon_data.push_back(pix_data);
          mon_flags.push_back({pix_sof, pix_eol, pix_eof});
          mon_cyc.push_back(cyc);
        end
        if (done) done_cnt++;
      end else begin
        req_stalled = 1'b0;
        pix_stalled = 1'b0;
      end

      @(posedge clk);
      #1;
      cyc++;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        rsp_a = pend_addr.pop_front();
        void'(pend_due.pop_front());
        rsp_off = int'(rsp_a - BASE);
        for (int b = 0; b < 128; b++) begin
          if (rsp_off + b >= 0 && rsp_off + b < FBBYTES)
            mem_rsp_data[8*b +: 8] = fbmem[rsp_off + b];
        end
        mem_rsp_valid = 1'b1;
      end
      if (stall_left > 0) begin
        mem_req_ready = 1'b0;
        stall_left--;
      end else begin
        mem_req_ready = 1'b1;
      end
      case (ready_mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = ~pix_ready;
        default: pix_ready = ($urandom_range(3) != 0);
      endcase
    end
  end

  // ---------------- reference model ----------------
  // Pixel (x,y) is bit x%8 of byte y*(W/8) + x/8 of the framebuffer.
  function automatic logic exp_pix(input int p);
    int x, y;
    logic [7:0] b;
    x = p % W;
    y = p / W;
    b = fbmem[y * (W / 8) + x / 8];
    return b[x % 8];
  endfunction

  task automatic fill_fb(input bit rnd);
    for (int i = 0; i < FBBYTES; i++) fbmem[i] = rnd ? 8'($urandom) : 8'h00;
  endtask

  task automatic run_frame(input int stall, input bit extra_starts, output bit timed_out);
    mon_data.delete(); mon_flags.delete(); mon_cyc.delete(); req_log.delete();
    done_cnt = 0;
    stab_err = 0;
    @(posedge clk); #1;
    stall_left = stall;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 30000; i++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) begin
        timed_out = 1'b0;
        break;
      end
      start = extra_starts && (i == 40 || i == 1500 || i == 3000);
    end
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input bit timed_out);
    int mism_d, mism_f, addr_bad;
    mism_d = 0; mism_f = 0; addr_bad = 0;
    check({tag, "/timeout"}, timed_out, 0);
    check({tag, "/done_pulses"}, done_cnt, 1);
    check({tag, "/pixel_count"}, mon_data.size(), NPIX);
    for (int p = 0; p < int'(mon_data.size()) && p < NPIX; p++) begin
      if (mon_data[p] !== exp_pix(p)) mism_d++;
      if (mon_flags[p] !== {p == 0, (p % W) == W - 1, p == NPIX - 1}) mism_f++;
    end
    check({tag, "/pixel_data_errors"}, mism_d, 0);
    check({tag, "/flag_errors"}, mism_f, 0);
    check({tag, "/request_count"}, req_log.size(), NLINES);
    for (int n = 0; n < int'(req_log.size()); n++)
      if (req_log[n] != BASE + 32'(128 * n)) addr_bad++;
    check({tag, "/request_addr_errors"}, addr_bad, 0);
    check({tag, "/stall_stability_errors"}, stab_err, 0);
    check({tag, "/busy_after"}, busy, 0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    string      name;
    int         addr;       // byte address to set, -1 for none
    logic [7:0] val;
    int         rmode;
    int         stall;
    int         latency;
    int         exp_ones;
    int         exp_first;  // first p with pix_data=1, -1 if none
  } vec_t;

  vec_t vecs [6];

  initial begin
    bit to, ok;
    int ones, first, g, maxgap;

    vecs[0] = '{"all_zero",   -1,     8'h00, 0, 0,  3,  0, -1};
    vecs[1] = '{"dot_2104",   'h2104, 8'h01, 0, 0,  3,  1, 2080};
    vecs[2] = '{"stall_alt",  -1,     8'h00, 1, 20, 3,  0, -1};
    vecs[3] = '{"row0_x7",    'h2000, 8'h80, 2, 0,  5,  1, 7};
    vecs[4] = '{"line1_x4",   'h2080, 8'h10, 0, 0,  1,  1, 1028};
    vecs[5] = '{"last_byte",  'h21FF, 8'hFF, 0, 0,  10, 8, 4088};

    fill_fb(1'b0);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset/ctrl_outputs", {busy, done, mem_req_valid, pix_valid, pix_data, pix_sof, pix_eol, pix_eof}, 0);
    check("reset/mem_req_addr", mem_req_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle/busy", busy, 0);

    foreach (vecs[i]) begin
      fill_fb(1'b0);
      if (vecs[i].addr >= 0) fbmem[vecs[i].addr - int'(BASE)] = vecs[i].val;
      lat        = vecs[i].latency;
      ready_mode = vecs[i].rmode;
      run_frame(vecs[i].stall, 1'b0, to);
      check_frame(vecs[i].name, to);
      ones = 0; first = -1;
      for (int p = 0; p < int'(mon_data.size()); p++)
        if (mon_data[p]) begin
          ones++;
          if (first < 0) first = p;
        end
      check({vecs[i].name, "/ones"}, ones, vecs[i].exp_ones);
      check({vecs[i].name, "/first_one"}, first, vecs[i].exp_first);
    end

    // Inter-line gap with latency 10 and a free-running sink.
    fill_fb(1'b1);
    lat = 10; ready_mode = 0;
    run_frame(0, 1'b0, to);
    check_frame("gap", to);
    if (mon_cyc.size() == NPIX) begin
`ifdef FB_SCANOUT_PREFETCH_EN
      maxgap = 0;
      for (int p = 1; p < NPIX; p++) begin
        g = int'(mon_cyc[p] - mon_cyc[p-1]) - 1;
        if (g > maxgap) maxgap = g;
      end
      check("gap/prefetch_max_gap", maxgap, 0);
`else
      for (int k = 1; k < NLINES; k++) begin
        g = int'(mon_cyc[1024*k] - mon_cyc[1024*k-1]) - 1;
        check_ge($sformatf("gap/line_gap_p%0d", 1024*k), g, 12);
      end
`endif
    end

    // start pulsed while busy must be ignored.
    fill_fb(1'b1);
    lat = 4; ready_mode = 0;
    run_frame(0, 1'b1, to);
    check_frame("start_busy", to);

    // Reset mid-frame at about p=1500, then a reset with a request still in flight.
    fill_fb(1'b1);
    lat = 10; ready_mode = 0;
    mon_data.delete(); mon_flags.delete(); mon_cyc.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (mon_data.size() >= 1500) begin ok = 1'b1; break; end
    end
    check("rst/reached_p1500", ok, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst/ctrl_outputs", {busy, done, mem_req_valid, pix_valid, pix_data, pix_sof, pix_eol, pix_eof}, 0);
    check("rst/mem_req_addr", mem_req_addr, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pend_due.size() > 0) begin ok = 1'b1; break; end
    end
    check("rst/request_in_flight", ok, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pend_due.size() == 0) begin ok = 1'b1; break; end
    end
    check("rst/stale_delivered", ok, 1);
    repeat (3) @(negedge clk);
    check("rst/idle_after_stale", {busy, pix_valid, mem_req_valid, done}, 0);
    run_frame(0, 1'b0, to);
    check_frame("rst/next_frame", to);

    // Random content, latency, sink backpressure and request stalls.
    for (int r = 0; r < 2; r++) begin
      fill_fb(1'b1);
      lat = $urandom_range(12, 1);
      ready_mode = 2;
      run_frame($urandom_range(30), 1'b0, to);
      check_frame($sformatf("random%0d", r), to);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_scanout.md
FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 Parameter FB_WIDTH, default 64, pixels per row.
REQ-002 Parameter FB_HEIGHT, default 64, rows per frame.
REQ-003 Parameter FB_BASE, default 32'h2000, byte address of the 1bpp framebuffer; 128-byte aligned.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins a frame scan.
REQ-007 busy  output  1  high from the cycle after start is accepted until done.
REQ-008 done  output  1  one-cycle pulse after the last pixel handshake.
REQ-009 mem_req_valid  output  1  memory line read request.
REQ-010 mem_req_ready  input  1  memory accepts the request.
REQ-011 mem_req_addr  output  32  byte address of the requested 128-byte line.
REQ-012 mem_rsp_valid  input  1  read data valid for one cycle.
REQ-013 mem_rsp_data  input  1024  returned line; byte b occupies bits [8b+7:8b].
REQ-014 pix_valid / pix_ready  output / input  1 / 1  pixel stream handshake.
REQ-015 pix_data  output  1  pixel value.
REQ-016 pix_sof / pix_eol / pix_eof  output  1 each  first pixel of frame / last pixel of row / last pixel of frame.

Function
REQ-017 Pixel (x,y) SHALL be bit (x mod 8) of byte FB_BASE + y*(FB_WIDTH/8) + x/8; linear index p=y*FB_WIDTH+x maps to line p/1024, bit p mod 1024.
REQ-018 Lines per frame L = FB_WIDTH*FB_HEIGHT/1024, at least 1; line n address = FB_BASE + 128*n.
REQ-019 FSM states: IDLE, REQ, WAIT, STREAM, FIN.
REQ-020 IDLE->REQ on start; start SHALL be ignored in every other state.
REQ-021 REQ: mem_req_valid=1; addr and valid held stable until mem_req_ready; then WAIT.
REQ-022 WAIT: the line buffer captures mem_rsp_data on mem_rsp_valid; then STREAM. mem_rsp_valid outside WAIT SHALL be ignored, except for a prefetch response (REQ-032).
REQ-023 STREAM: pixels emitted in ascending p order, one per pix_valid&&pix_ready cycle; pix_data and flags held stable while pix_valid&&!pix_ready.
REQ-024 pix_sof=1 only for p=0; pix_eol=1 when x=FB_WIDTH-1; pix_eof=1 only for p=FB_WIDTH*FB_HEIGHT-1.
REQ-025 After bit 1023 of line n handshakes: n<L-1 -> REQ for n+1; n=L-1 -> FIN.
REQ-026 FIN: done=1 for exactly one cycle, busy=0 the same cycle, then IDLE.
REQ-027 The first pixel of a line SHALL be valid the cycle after the response is captured.
REQ-028 The pixel counter SHALL be log2(FB_WIDTH*FB_HEIGHT)+1 bits with no wrap within a frame.

Reset
REQ-029 rst_n low, at any time including mid-frame, SHALL force IDLE and zero busy, done, mem_req_valid, mem_req_addr, pix_valid, pix_data, pix_sof, pix_eol, pix_eof, and all counters.
REQ-030 A response arriving after reset deassertion for a request issued before reset SHALL be ignored.

Configuration
REQ-031 Macro FB_SCANOUT_PREFETCH_EN adds a second line buffer.
REQ-032 With the macro: during STREAM of line n<L-1, the request for n+1 SHALL be issued and its response captured into the spare buffer; at line end STREAM continues with zero gap if the data has arrived, otherwise it waits in WAIT.
REQ-033 Without the macro: single buffer; the next request is issued only after the line's last pixel, giving a gap of at least memory latency+2 cycles.
REQ-034 The pixel stream content SHALL be identical in both builds.

Verification
REQ-035 All-zero FB, start, pix_ready=1 -> 4096 pixels all 0; requests at 0x2000, 0x2080, 0x2100, 0x2180; sof at p=0, eol every 64, eof at p=4095; a single done pulse.
REQ-036 Only byte 0x2104 = 8'h01 -> pix_data=1 only at p=2080 (x=32,y=32).
REQ-037 pix_ready alternating 1/0, and mem_req_ready low for 20 cycles -> same stream as REQ-035; data and addr stable while stalled.
REQ-038 rst_n pulsed low at p=1500, then start -> all outputs 0 during reset; the next frame is complete from p=0; stale response ignored.
REQ-039 start pulsed during busy -> ignored, exactly one done.
REQ-040 Memory latency 10, pix_ready=1 -> with FB_SCANOUT_PREFETCH_EN, no pix_valid gap after p=0; without it, gaps of at least 12 cycles at p=1024, 2048 and 3072.
